// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: fetch FSM states, IF/ID payload, opcode map.
package riscv_pkg;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {F_REQ, F_WAIT, F_HOLD} fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_word_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats hold beats load; empty slot carries a NOP.
module ifid_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       stall,
  input  logic       load,
  input  ifid_word_t load_word,
  output logic       valid,
  output ifid_word_t word
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      word  <= '{instr: NOP_INSTR, pc: 32'h0};
    end else if (flush) begin
      valid      <= 1'b0;
      word.instr <= NOP_INSTR;
    end else if (!(stall && valid)) begin
      if (load) begin
        valid <= 1'b1;
        word  <= load_word;
      end else begin
        valid      <= 1'b0;
        word.instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with one outstanding imem request, skid slot and IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n, fetch_pc, fetch_pc_n, skid, skid_n;
  logic         kill, kill_n, ifid_free, hs, load;
  ifid_word_t   load_word, ifid_word;

  assign ifid_free      = !ifid_valid || !id_stall;
  assign imem_req_valid = (state == F_REQ) && !rst;
  assign imem_req_addr  = pc & ~32'h3;
  assign hs             = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= F_REQ;
      pc       <= RESET_PC;
      fetch_pc <= 32'h0;
      skid     <= NOP_INSTR;
      kill     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      fetch_pc <= fetch_pc_n;
      skid     <= skid_n;
      kill     <= kill_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    fetch_pc_n = fetch_pc;
    skid_n     = skid;
    kill_n     = kill;
    load       = 1'b0;
    load_word  = '{instr: imem_rsp_data, pc: fetch_pc};
    case (state)
      F_REQ: begin
        if (hs) begin
          fetch_pc_n = pc;
          pc_n       = pc + 32'd4;
          state_n    = F_WAIT;
          kill_n     = redirect_valid;  // request already left; its word is wrong-path
        end
      end
      F_WAIT: begin
        if (imem_rsp_valid) begin
          kill_n  = 1'b0;
          state_n = F_REQ;
          if (!kill && !redirect_valid) begin
            if (ifid_free) begin
              load = 1'b1;
            end else begin
              skid_n  = imem_rsp_data;
              state_n = F_HOLD;
            end
          end
        end else if (redirect_valid) begin
          kill_n = 1'b1;
        end
      end
      F_HOLD: begin
        if (redirect_valid) begin
          state_n = F_REQ;
        end else if (ifid_free) begin
          load            = 1'b1;
          load_word.instr = skid;
          state_n         = F_REQ;
        end
      end
      default: state_n = F_REQ;
    endcase
    // Redirect overrides the sequential PC; the new address is requested next cycle at earliest.
    if (redirect_valid) pc_n = redirect_pc & ~32'h3;
  end

  ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .stall     (id_stall),
    .load      (load),
    .load_word (load_word),
    .valid     (ifid_valid),
    .word      (ifid_word)
  );

  assign ifid_instr = ifid_word.instr;
  assign ifid_pc    = ifid_word.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against an in-order stream model.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ready, rsp_valid, redirect_valid, id_stall;
  logic [31:0] rsp_data, redirect_pc;
  logic        req_valid, ifid_valid;
  logic [31:0] req_addr, ifid_instr, ifid_pc;

  logic        rst_w, ready_w, rsp_valid_w, redir_w, stall_w;
  logic [31:0] rsp_data_w, redir_pc_w;
  logic        req_valid_w, ifid_valid_w;
  logic [31:0] req_addr_w, ifid_instr_w, ifid_pc_w;

  int tests = 0, fails = 0;
  int lat = 1, pend_cnt = 0;
  bit pend = 0, outst = 0;
  logic [31:0] pend_addr = '0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_req_valid(req_valid), .imem_req_ready(ready),
    .imem_req_addr(req_addr), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .imem_req_valid(req_valid_w), .imem_req_ready(ready_w),
    .imem_req_addr(req_addr_w), .imem_rsp_valid(rsp_valid_w), .imem_rsp_data(rsp_data_w),
    .redirect_valid(redir_w), .redirect_pc(redir_pc_w), .id_stall(stall_w),
    .ifid_valid(ifid_valid_w), .ifid_instr(ifid_instr_w), .ifid_pc(ifid_pc_w)
  );

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // One clock: sample the handshake, cross the edge, then play the memory model
  // (response exactly lat cycles after acceptance).
  task automatic tick();
    logic hs;
    logic [31:0] a;
    #1;
    hs = req_valid && ready && !rst;
    a  = req_addr;
    if (rsp_valid) assert (outst) else $error("response driven with no request outstanding");
    @(posedge clk);
    @(negedge clk);
    if (rsp_valid) outst = 0;
    rsp_valid = 1'b0;
    if (rst) begin
      pend = 0; outst = 0;
    end else if (hs) begin
      pend = 1; outst = 1; pend_addr = a; pend_cnt = lat - 1;
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        rsp_valid = 1'b1; rsp_data = mem(pend_addr); pend = 0;
      end else pend_cnt--;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_stall = 1'b0;
    lat = 1; rsp_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_stall = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
      tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL reset_ifid_valid got %b want 0", ifid_valid); end
      tests++; if (ifid_instr !== NOP_WORD) begin fails++; $display("FAIL reset_ifid_instr got %h want %h", ifid_instr, NOP_WORD); end
      tests++; if (ifid_pc !== 32'h0) begin fails++; $display("FAIL reset_ifid_pc got %h want 0", ifid_pc); end
    end
    rst = 1'b0;
    #1;
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin fails++; $display("FAIL reset_first_req got v=%b a=%h want v=1 a=0", req_valid, req_addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      tests++; if (req_valid !== (k % 2 == 0)) begin fails++; $display("FAIL seq_req_valid c%0d got %b want %b", k, req_valid, k % 2 == 0); end
      if (k % 2 == 0) begin
        tests++; if (req_addr !== 32'(2 * k)) begin fails++; $display("FAIL seq_req_addr c%0d got %h want %h", k, req_addr, 2 * k); end
      end
      tests++; if (ifid_valid !== (k >= 2 && k % 2 == 0)) begin fails++; $display("FAIL seq_ifid_valid c%0d got %b", k, ifid_valid); end
      if (k >= 2 && k % 2 == 0) begin
        tests++; if (ifid_pc !== 32'(2 * k - 4) || ifid_instr !== mem(32'(2 * k - 4)))
          begin fails++; $display("FAIL seq_ifid c%0d got pc=%h i=%h want pc=%h", k, ifid_pc, ifid_instr, 2 * k - 4); end
      end else begin
        tests++; if (ifid_instr !== NOP_WORD) begin fails++; $display("FAIL seq_bubble c%0d got %h want %h", k, ifid_instr, NOP_WORD); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (4) tick();
    id_stall = 1'b1;
    for (int k = 4; k < 10; k++) begin
      if (k == 9) id_stall = 1'b0;
      tests++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4 || ifid_instr !== mem(32'h4))
        begin fails++; $display("FAIL stall_hold c%0d got v=%b pc=%h want v=1 pc=4", k, ifid_valid, ifid_pc); end
      if (k >= 5) begin
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL stall_no_req c%0d got %b want 0", k, req_valid); end
      end
      tick();
    end
    tests++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8 || ifid_instr !== mem(32'h8))
      begin fails++; $display("FAIL stall_release got v=%b pc=%h want pc=8", ifid_valid, ifid_pc); end
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'hC) begin fails++; $display("FAIL stall_next_req got v=%b a=%h want a=c", req_valid, req_addr); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    repeat (4) tick();
    lat = 3;
    tick();
    lat = 1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    tests++; if (req_valid !== 1'b0 || ifid_valid !== 1'b0) begin fails++; $display("FAIL redir_wait_c6 got req=%b ifv=%b want 0 0", req_valid, ifid_valid); end
    tick();
    tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL redir_wait_c7 got req=%b want 0", req_valid); end
    tick();
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL redir_wait_drop got ifv=%b pc=%h want 0", ifid_valid, ifid_pc); end
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h40) begin fails++; $display("FAIL redir_wait_req got v=%b a=%h want a=40", req_valid, req_addr); end
    tick(); tick();
    tests++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h40 || ifid_instr !== mem(32'h40))
      begin fails++; $display("FAIL redir_wait_target got v=%b pc=%h want pc=40", ifid_valid, ifid_pc); end
  endtask

  task automatic test_redirect_rsp_stall();
    do_reset();
    repeat (4) tick();
    id_stall = 1'b1;
    tick();
    tests++; if (rsp_valid !== 1'b1 || ifid_pc !== 32'h4) begin fails++; $display("FAIL rsp_stall_setup got rsp=%b pc=%h want 1 4", rsp_valid, ifid_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0; id_stall = 1'b0;
    tests++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP_WORD) begin fails++; $display("FAIL rsp_stall_flush got v=%b i=%h want 0 %h", ifid_valid, ifid_instr, NOP_WORD); end
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h80) begin fails++; $display("FAIL rsp_stall_req got v=%b a=%h want a=80", req_valid, req_addr); end
    tick(); tick();
    tests++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h80 || ifid_instr !== mem(32'h80))
      begin fails++; $display("FAIL rsp_stall_target got v=%b pc=%h want pc=80", ifid_valid, ifid_pc); end
  endtask

  task automatic test_redirect_req_hs();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL req_hs_wait got %b want 0", req_valid); end
    tick();
    tests++; if (ifid_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h200)
      begin fails++; $display("FAIL req_hs_kill got ifv=%b req=%b a=%h want 0 1 200", ifid_valid, req_valid, req_addr); end
    tick(); tick();
    tests++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200 || ifid_instr !== mem(32'h200))
      begin fails++; $display("FAIL req_hs_target got v=%b pc=%h want pc=200", ifid_valid, ifid_pc); end
  endtask

  task automatic test_ready_low();
    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin fails++; $display("FAIL ready_low c%0d got v=%b a=%h want 1 0", k, req_valid, req_addr); end
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin fails++; $display("FAIL ready_low_redir_cycle got v=%b a=%h want 1 0", req_valid, req_addr); end
    tick();
    redirect_valid = 1'b0; ready = 1'b1;
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin fails++; $display("FAIL ready_low_align got v=%b a=%h want 1 100", req_valid, req_addr); end
    tick(); tick();
    tests++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100 || ifid_instr !== mem(32'h100))
      begin fails++; $display("FAIL ready_low_target got v=%b pc=%h want pc=100", ifid_valid, ifid_pc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (4) tick();
    id_stall = 1'b1; lat = 3;
    tick();
    tests++; if (ifid_valid !== 1'b1 || req_valid !== 1'b0) begin fails++; $display("FAIL async_setup got ifv=%b req=%b want 1 0", ifid_valid, req_valid); end
    #2 rst = 1'b1;
    #1;
    tests++; if (req_valid !== 1'b0 || ifid_valid !== 1'b0 || ifid_instr !== NOP_WORD || ifid_pc !== 32'h0)
      begin fails++; $display("FAIL async_reset got req=%b ifv=%b i=%h pc=%h", req_valid, ifid_valid, ifid_instr, ifid_pc); end
    tick();
    id_stall = 1'b0; lat = 1; rst = 1'b0;
    #1;
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin fails++; $display("FAIL async_restart got v=%b a=%h want 1 0", req_valid, req_addr); end
  endtask

  task automatic test_wrap();
    rst_w = 1'b0;
    #1;
    tests++; if (req_valid_w !== 1'b1 || req_addr_w !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_first got v=%b a=%h want fffffffc", req_valid_w, req_addr_w); end
    tick();
    rsp_valid_w = 1'b1; rsp_data_w = 32'hCAFE_0001;
    tests++; if (req_valid_w !== 1'b0) begin fails++; $display("FAIL wrap_wait got %b want 0", req_valid_w); end
    tick();
    rsp_valid_w = 1'b0;
    tests++; if (req_valid_w !== 1'b1 || req_addr_w !== 32'h0) begin fails++; $display("FAIL wrap_second got v=%b a=%h want 1 0", req_valid_w, req_addr_w); end
    tests++; if (ifid_valid_w !== 1'b1 || ifid_pc_w !== 32'hFFFF_FFFC || ifid_instr_w !== 32'hCAFE_0001)
      begin fails++; $display("FAIL wrap_ifid got v=%b pc=%h i=%h", ifid_valid_w, ifid_pc_w, ifid_instr_w); end
  endtask

  // Decoder-side view: every instruction consumed must continue the program-order
  // stream that restarts at each (aligned) redirect target.
  task automatic test_random();
    logic [31:0] exp_pc, p_pc, p_instr, p_addr;
    bit p_hold, p_redir, p_reqwait;
    int consumed;
    do_reset();
    exp_pc = 32'h0; consumed = 0;
    p_hold = 0; p_redir = 0; p_reqwait = 0; p_pc = '0; p_instr = '0; p_addr = '0;
    for (int i = 0; i < 3000; i++) begin
      ready          = ($urandom_range(0, 9) < 7);
      id_stall       = ($urandom_range(0, 9) < 3);
      lat            = int'($urandom_range(1, 3));
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom_range(0, 1023);
      if (!redirect_valid && ifid_valid && !id_stall) begin
        tests++; if (ifid_pc !== exp_pc || ifid_instr !== mem(exp_pc))
          begin fails++; $display("FAIL rnd_stream cyc%0d got pc=%h i=%h want pc=%h i=%h", i, ifid_pc, ifid_instr, exp_pc, mem(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (!ifid_valid) begin
        tests++; if (ifid_instr !== NOP_WORD) begin fails++; $display("FAIL rnd_nop cyc%0d got %h want %h", i, ifid_instr, NOP_WORD); end
      end
      if (req_valid) begin
        tests++; if (req_addr[1:0] !== 2'b00) begin fails++; $display("FAIL rnd_align cyc%0d got %h", i, req_addr); end
      end
      if (p_hold) begin
        tests++; if (ifid_valid !== 1'b1 || ifid_pc !== p_pc || ifid_instr !== p_instr)
          begin fails++; $display("FAIL rnd_hold cyc%0d got v=%b pc=%h want pc=%h", i, ifid_valid, ifid_pc, p_pc); end
      end
      if (p_redir) begin
        tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL rnd_flush cyc%0d got %b want 0", i, ifid_valid); end
      end
      if (p_reqwait) begin
        tests++; if (req_valid !== 1'b1 || req_addr !== p_addr)
          begin fails++; $display("FAIL rnd_req_stable cyc%0d got v=%b a=%h want 1 %h", i, req_valid, req_addr, p_addr); end
      end
      if (outst) begin
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL rnd_outstanding cyc%0d got req=%b want 0", i, req_valid); end
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      p_hold    = id_stall && ifid_valid && !redirect_valid;
      p_pc      = ifid_pc;
      p_instr   = ifid_instr;
      p_redir   = redirect_valid;
      p_reqwait = req_valid && !ready && !redirect_valid;
      p_addr    = req_addr;
      tick();
    end
    redirect_valid = 1'b0; id_stall = 1'b0;
    tests++; if (consumed < 200) begin fails++; $display("FAIL rnd_progress got %0d instrs want >= 200", consumed); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_w = 1'b1; ready_w = 1'b1; rsp_valid_w = 1'b0; rsp_data_w = '0;
    redir_w = 1'b0; redir_pc_w = '0; stall_w = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp_stall();
    test_redirect_req_hs();
    test_ready_low();
    test_async_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
